// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register carrying {pc, inst} over a valid/ready handshake with a 2-entry skid buffer.
// Optional back-pressure counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int                 PC_W     = 32,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              m_valid;
    logic [PC_W-1:0]   m_pc;
    logic [INST_W-1:0] m_inst;
    logic              s_valid;
    logic [PC_W-1:0]   s_pc;
    logic [INST_W-1:0] s_inst;
    logic              in_fire;
    logic              m_free;

    // in_ready is a pure function of the skid flop, so it is registered by construction.
    assign in_ready  = ~s_valid;
    assign in_fire   = in_valid & in_ready;
    assign m_free    = ~m_valid | out_ready;

    assign out_valid = m_valid;
    assign out_pc    = m_pc;
    assign out_inst  = m_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_inst  <= NOP_INST;
            s_valid <= 1'b0;
            s_pc    <= '0;
            s_inst  <= NOP_INST;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_inst  <= NOP_INST;
            s_valid <= 1'b0;
            s_pc    <= '0;
            s_inst  <= NOP_INST;
        end else if (m_free) begin
            if (s_valid) begin
                // Skid drains first; in_ready was low, so no new beat competes.
                m_valid <= 1'b1;
                m_pc    <= s_pc;
                m_inst  <= s_inst;
                s_valid <= 1'b0;
                s_inst  <= NOP_INST;
            end else if (in_fire) begin
                m_valid <= 1'b1;
                m_pc    <= in_pc;
                m_inst  <= in_inst;
            end else begin
                m_valid <= 1'b0;
                m_inst  <= NOP_INST;
            end
        end else if (in_fire) begin
            s_valid <= 1'b1;
            s_pc    <= in_pc;
            s_inst  <= in_inst;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] cnt;

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (m_valid && !out_ready && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
